// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event front end.
// Each channel's level input is synchronized, and its rising/falling edges are
// detected and held as one pending event per channel. Pending events are
// granted round-robin onto a single valid/ready port. An edge that hits an
// occupied pending slot is dropped and raises a sticky overflow flag.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int ID_W        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sig_in,
  input  logic [N_CH-1:0] pos_en,
  input  logic [N_CH-1:0] neg_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_rising,
  output logic [N_CH-1:0] overflow,
  input  logic            ovf_clr
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state;
  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   prev_q;
  logic [N_CH-1:0]   sync_s;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   fall;
  logic [N_CH-1:0]   edge_any;
  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   pend_type;
  logic [N_CH-1:0]   hs_vec;
  logic [N_CH-1:0]   ovf_set;
  logic              hs;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   idx;
  logic              found;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == WARM_W'(WARM_MAX));
  assign rise      = warm_done ? (sync_s & ~prev_q & pos_en) : '0;
  assign fall      = warm_done ? (~sync_s & prev_q & neg_en) : '0;
  assign edge_any  = rise | fall;
  assign hs        = evt_valid & evt_ready;
  assign ovf_set   = edge_any & pending & ~hs_vec;

  // Synchronizer chain and previous-value register feeding the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_s;
    end
  end

  // Warm-up counter keeps detection off until the chain holds real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  // One-hot marker of the channel whose event is accepted this cycle.
  always_comb begin
    hs_vec = '0;
    if (hs) hs_vec[evt_id] = 1'b1;
  end

  // Per-channel pending slot: load on edge, reload on same-cycle grant, clear on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      pend_type <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (edge_any[i]) begin
          if (!pending[i] || hs_vec[i]) begin
            pending[i]   <= 1'b1;
            pend_type[i] <= rise[i];
          end
        end else if (hs_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flags; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
    end
  end

  // Round-robin search for the first pending channel after the last grant.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ID_W'((int'(last) + 1 + k) % N_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Offer FSM with registered outputs; one bubble cycle follows every handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_rising <= 1'b0;
      last       <= ID_W'(N_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            evt_id     <= sel;
            evt_rising <= pend_type[sel];
            evt_valid  <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            last      <= evt_id;
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
